// File: rtl/rfphoenix_vec_wb_pkg.sv
// Shared types for the vector write-back buffer: lane count, register
// specifier, vector value and the buffered entry payload.
package rfPhoenixPkg;

    localparam int unsigned NLANES = 4;
    localparam int unsigned LANE_W = 32;
    localparam int unsigned REG_W  = 6;

    typedef logic [REG_W-1:0] Regspec;
    typedef logic [NLANES-1:0][LANE_W-1:0] VecValue;

    typedef struct packed {
        Regspec              tgt;
        logic [NLANES-1:0]   mask;
        VecValue             value;
    } WbEntry;

endpackage

// File: rtl/rfphoenix_wb_fwd_lane.sv
// Per-lane youngest-match selector: candidates arrive ordered oldest (index 0)
// to youngest, so the last asserted candidate wins.
module rfphoenix_wb_fwd_lane
    import rfPhoenixPkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic [DEPTH-1:0]             cand,
    input  logic [DEPTH-1:0][LANE_W-1:0] vals,
    output logic                         hit,
    output logic [LANE_W-1:0]            dat
);

    always_comb begin
        hit = 1'b0;
        dat = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (cand[k]) begin
                hit = 1'b1;
                dat = vals[k];
            end
        end
    end

endmodule

// File: rtl/rfphoenix_vec_wb.sv
// Vector ALU write-back buffer: circular FIFO in front of the vector register
// file, with per-lane forwarding of the youngest buffered result.
module rfphoenix_vec_wb
    import rfPhoenixPkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  Regspec                   in_tgt,
    input  logic [NLANES-1:0]        in_mask,
    input  VecValue                  in_res,
    output logic                     rf_we,
    input  logic                     rf_ready,
    output Regspec                   rf_tgt,
    output logic [NLANES-1:0]        rf_mask,
    output VecValue                  rf_dat,
    input  Regspec                   fwd_reg,
    output logic [NLANES-1:0]        fwd_hit,
    output VecValue                  fwd_dat,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    WbEntry           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push;
    logic             pop;
    WbEntry           head;

    logic [NLANES-1:0][DEPTH-1:0]             cand;
    logic [NLANES-1:0][DEPTH-1:0][LANE_W-1:0] vals;

    assign in_ready = count < CNT_W'(DEPTH);
    assign rf_we    = count != '0;

    // Null writes (no lanes, or register 0) are consumed without occupying a slot.
    assign push = in_valid && in_ready && (in_mask != '0) && (in_tgt != '0);
    assign pop  = rf_we && rf_ready;

    assign head    = mem[rd_ptr];
    assign rf_tgt  = head.tgt;
    assign rf_mask = head.mask;
    assign rf_dat  = head.value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage is not reset; occupancy alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= '{tgt: in_tgt, mask: in_mask, value: in_res};
        end
    end

    // Present the valid slots to the lane selectors in age order, oldest first.
    always_comb begin
        logic [PTR_W-1:0] slot;
        logic             match;
        cand  = '0;
        vals  = '0;
        slot  = '0;
        match = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            slot  = rd_ptr + PTR_W'(k);
            match = (CNT_W'(k) < count) && (fwd_reg != '0) && (mem[slot].tgt == fwd_reg);
            for (int l = 0; l < NLANES; l++) begin
                cand[l][k] = match && mem[slot].mask[l];
                vals[l][k] = mem[slot].value[l];
            end
        end
    end

    for (genvar l = 0; l < NLANES; l++) begin : g_lane
        rfphoenix_wb_fwd_lane #(
            .DEPTH (DEPTH)
        ) u_lane (
            .cand (cand[l]),
            .vals (vals[l]),
            .hit  (fwd_hit[l]),
            .dat  (fwd_dat[l])
        );
    end

endmodule

// File: tb/tb_rfphoenix_vec_wb.sv
// Directed plus random bench for the vector write-back buffer, checked
// against a queue model of the buffered entries.
module tb_rfphoenix_vec_wb;
    import rfPhoenixPkg::*;

    localparam int unsigned DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    Regspec            in_tgt;
    logic [NLANES-1:0] in_mask;
    VecValue           in_res;
    logic              rf_we;
    logic              rf_ready;
    Regspec            rf_tgt;
    logic [NLANES-1:0] rf_mask;
    VecValue           rf_dat;
    Regspec            fwd_reg;
    logic [NLANES-1:0] fwd_hit;
    VecValue           fwd_dat;
    logic [$clog2(DEPTH):0] count;

    int     n_cmp = 0;
    int     n_err = 0;
    WbEntry sb[$];

    rfphoenix_vec_wb #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_tgt   (in_tgt),
        .in_mask  (in_mask),
        .in_res   (in_res),
        .rf_we    (rf_we),
        .rf_ready (rf_ready),
        .rf_tgt   (rf_tgt),
        .rf_mask  (rf_mask),
        .rf_dat   (rf_dat),
        .fwd_reg  (fwd_reg),
        .fwd_hit  (fwd_hit),
        .fwd_dat  (fwd_dat),
        .count    (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic VecValue mkv(input logic [LANE_W-1:0] base);
        VecValue v;
        for (int l = 0; l < NLANES; l++) v[l] = base * LANE_W'(l + 1);
        return v;
    endfunction

    function automatic void fwd_model(input Regspec r, output logic [NLANES-1:0] h, output VecValue d);
        h = '0;
        d = '0;
        if (r != '0) begin
            foreach (sb[i]) begin
                if (sb[i].tgt == r) begin
                    for (int l = 0; l < NLANES; l++) begin
                        if (sb[i].mask[l]) begin
                            h[l] = 1'b1;
                            d[l] = sb[i].value[l];
                        end
                    end
                end
            end
        end
    endfunction

    // Check outputs against the model mid-cycle, advance the model, step one edge.
    task automatic cycle();
        logic [NLANES-1:0] eh;
        VecValue           ed;
        WbEntry            e;
        bit                rdy_exp;
        #1;
        rdy_exp = sb.size() < DEPTH;
        chk("in_ready", in_ready, rdy_exp);
        chk("rf_we", rf_we, sb.size() != 0);
        chk("count", count, sb.size());
        fwd_model(fwd_reg, eh, ed);
        chk("fwd_hit", fwd_hit, eh);
        chk("fwd_dat", fwd_dat, ed);
        if (sb.size() != 0) chk("rf_head", {rf_tgt, rf_mask, rf_dat}, sb[0]);
        if (flush) begin
            sb.delete();
        end else begin
            if (rf_ready && sb.size() != 0) void'(sb.pop_front());
            if (in_valid && rdy_exp && in_mask != '0 && in_tgt != '0) begin
                e.tgt   = in_tgt;
                e.mask  = in_mask;
                e.value = in_res;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        VecValue va;
        VecValue vb;
        VecValue vexp;

        flush = 0; in_valid = 0; in_tgt = '0; in_mask = '0; in_res = '0;
        rf_ready = 0; fwd_reg = '0;

        #1 rst = 1;
        #10;
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_count", count, 0);
        chk("rst_fwd_hit", fwd_hit, '0);
        @(negedge clk) rst = 0;
        @(posedge clk);
        #1;

        // single push, immediate drain
        in_valid = 1; in_tgt = 5; in_mask = '1; in_res = mkv(32'h11); rf_ready = 1;
        cycle();
        in_valid = 0;
        chk("one_rf_we", rf_we, 1'b1);
        chk("one_rf_tgt", rf_tgt, 5);
        chk("one_rf_dat", rf_dat, mkv(32'h11));
        cycle();
        chk("one_count", count, 0);
        chk("one_rf_we_low", rf_we, 1'b0);

        // fill past capacity with the register file stalled, then drain
        rf_ready = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            in_valid = 1; in_tgt = Regspec'(i + 1); in_mask = '1;
            in_res = mkv(LANE_W'(32'h100 * (i + 1)));
            cycle();
        end
        in_valid = 0;
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_count", count, DEPTH);
        rf_ready = 1;
        repeat (DEPTH) cycle();
        chk("drain_count", count, 0);

        // forwarding picks the youngest writer per lane
        rf_ready = 0;
        va = mkv(32'hA0);
        vb = mkv(32'hB0);
        in_valid = 1; in_tgt = 7; in_mask = 4'h1; in_res = va;
        cycle();
        in_tgt = 7; in_mask = 4'h3; in_res = vb;
        cycle();
        in_valid = 0;
        fwd_reg = 7;
        #1;
        vexp = '0;
        vexp[0] = vb[0];
        vexp[1] = vb[1];
        chk("fwd7_hit", fwd_hit, 4'h3);
        chk("fwd7_dat", fwd_dat, vexp);
        in_valid = 1; in_tgt = 8; in_mask = '1; in_res = mkv(32'hC0);
        fwd_reg = 8;
        #1;
        chk("fwd8_hit", fwd_hit, '0);
        chk("fwd8_dat", fwd_dat, '0);
        cycle();
        in_tgt = 9; in_res = mkv(32'hD0);
        cycle();

        // full buffer: pop goes ahead, push is held off
        in_tgt = 10; in_res = mkv(32'hE0); rf_ready = 1;
        cycle();
        chk("fullpop_count", count, 3);
        rf_ready = 0;

        // flush wins over a concurrent push
        flush = 1; in_tgt = 11; in_res = mkv(32'hF0);
        cycle();
        flush = 0; in_valid = 0;
        chk("flush_count", count, 0);
        chk("flush_rf_we", rf_we, 1'b0);

        // null writes are swallowed
        in_valid = 1; in_tgt = 5; in_mask = '0;
        cycle();
        in_tgt = 0; in_mask = '1;
        cycle();
        in_valid = 0;
        cycle();
        chk("null_count", count, 0);
        chk("null_in_ready", in_ready, 1'b1);

        // reset in the middle of a drain
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_tgt = Regspec'(12 + i); in_mask = '1;
            in_res = mkv(LANE_W'(32'h1000 * (i + 1)));
            cycle();
        end
        in_valid = 0; rf_ready = 1;
        cycle();
        #2 rst = 1;
        #1;
        chk("midrst_rf_we", rf_we, 1'b0);
        chk("midrst_count", count, 0);
        chk("midrst_in_ready", in_ready, 1'b1);
        sb.delete();
        #2 rst = 0;
        rf_ready = 0;

        // random traffic
        repeat (80) begin
            in_valid = 1'($urandom);
            in_tgt   = Regspec'($urandom_range(0, 3));
            in_mask  = NLANES'($urandom);
            in_res   = {$urandom, $urandom, $urandom, $urandom};
            rf_ready = 1'($urandom);
            fwd_reg  = Regspec'($urandom_range(0, 3));
            flush    = ($urandom_range(0, 7) == 0);
            cycle();
        end
        in_valid = 0; flush = 0; rf_ready = 1;
        repeat (DEPTH + 2) cycle();
        chk("end_count", count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
